// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded arbiter sharing one FIFO write port
// between NUM_REQ valid/ready producers; never writes while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          err_overflow
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d, ptr, win;
    logic [3:0]    beat_q, beat_d;
    logic          err_q, any, burst_end;

    // Scan far-to-near so the requester closest after ptr overwrites the others;
    // ptr itself comes last in priority.
    always_comb begin
        ptr = (state_q == GRANT) ? grant_q : last_q;
        win = '0;
        any = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[IW'((int'(ptr) + i) % NUM_REQ)]) begin
                win = IW'((int'(ptr) + i) % NUM_REQ);
                any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            err_q   <= err_q | fifo_overflow;
        end
    end

    assign burst_end = (state_q == GRANT) &&
                       ((fifo_wr_en && beat_q == 4'(MAX_BURST - 1)) || !req_valid[grant_q]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        if (state_q == IDLE) begin
            if (any) begin
                state_d = GRANT;
                grant_d = win;
                beat_d  = '0;
            end
        end else if (burst_end) begin
            last_d  = grant_q;
            state_d = any ? GRANT : IDLE;
            grant_d = any ? win : grant_q;
            beat_d  = '0;
        end else if (fifo_wr_en) begin
            beat_d = beat_q + 4'd1;
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        if (state_q == GRANT) begin
            req_ready[grant_q] = ~fifo_full;
            fifo_wr_en         = req_valid[grant_q] & ~fifo_full;
            fifo_data_in       = req_data[grant_q*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign grant_id     = grant_q;
    assign busy         = (state_q == GRANT);
    assign err_overflow = err_q;
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port between NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for bounded bursts and drives the FIFO wr_en/data_in. It never issues a write while the FIFO reports full, and it flags any overflow the FIFO reports. The block sits directly in front of the FIFO write side in the FIFO_top hierarchy.

Parameters:
NUM_REQ, 4, number of producers (2..8)
FIFO_WIDTH, 16, data width per producer and FIFO word width
MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-producer data valid
req_data  in  NUM_REQ*FIFO_WIDTH  producer i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH]
req_ready  out  NUM_REQ  per-producer accept; combinational
fifo_wr_en  out  1  FIFO write enable; combinational
fifo_data_in  out  FIFO_WIDTH  data of granted producer; combinational mux
fifo_full  in  1  FIFO full flag
fifo_overflow  in  1  FIFO overflow pulse
grant_id  out  $clog2(NUM_REQ)  registered index of the current grant holder
busy  out  1  registered; 1 while in GRANT state
err_overflow  out  1  sticky overflow error

Behaviour:
- Async reset:
  - state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (so producer 0 has top priority), beat_cnt=0, busy=0, err_overflow=0.
  - req_ready, fifo_wr_en and fifo_data_in are all 0 during reset.
  - Reset mid-burst abandons the burst; no partial state survives.
- States: IDLE, GRANT.
- Arbitration:
  - Pick the first asserted req_valid scanning from last_grant+1, wrapping modulo NUM_REQ.
  - The winner is registered into grant_id on the clock edge, so there is 1 cycle of latency from IDLE to the first beat.
- IDLE: if any req_valid, arbitrate, go to GRANT, beat_cnt=0. Otherwise stay.
- GRANT, with g = grant_id:
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_data_in = req_data[g] (0 when not in GRANT).
  - Each cycle with fifo_wr_en=1 is one beat; beat_cnt increments.
- Burst end occurs when either:
  - a beat occurs with beat_cnt==MAX_BURST-1, or
  - req_valid[g]==0.
- At burst end:
  - last_grant <= g.
  - Re-arbitrate on the same edge over the current req_valid with g at lowest priority.
  - If a winner exists: stay in GRANT, load grant_id, beat_cnt=0, with no bubble cycle. g may win again if it is the only requester.
  - If no winner: go to IDLE.
- fifo_full=1 in GRANT:
  - No beat; beat_cnt holds; grant is kept while req_valid[g]=1.
  - If the producer drops valid while stalled, the burst ends as above.
- Producers must hold req_valid/req_data stable until ready. The arbiter does not latch data.
- err_overflow sets on any cycle with fifo_overflow=1 and clears only on reset.
- Safety invariants:
  - fifo_wr_en=1 implies fifo_full=0.
  - req_ready is one-hot or zero.
  - fifo_wr_en equals the OR of (req_valid & req_ready).

Test Plan:
- Reset check: assert rst_n=0 mid-burst with producer 1 streaming -> req_ready=0, fifo_wr_en=0, busy=0, grant_id=0 immediately (no clock). After release, with all producers valid, producer 0 is granted first.
- Single producer, MAX_BURST=4, fifo_full=0: producer 2 holds valid for 6 beats (D0..D5) -> busy rises 1 cycle after valid. fifo_wr_en is high for 6 consecutive cycles with no bubble at the burst-4 boundary. grant_id=2 throughout. The FIFO receives D0..D5 in order.
- Fairness: all four producers hold valid continuously -> grant sequence 0,1,2,3,0, each exactly 4 beats. Beat 4 of one grant and beat 1 of the next are on adjacent cycles.
- Backpressure: while producer 1 is granted at beat 2, drive fifo_full=1 for 3 cycles -> req_ready[1]=0, fifo_wr_en=0, beat_cnt held at 2. After full drops, exactly 2 more beats complete before re-arbitration.
- Early release: producer 3 drops valid after 1 beat while producer 0 is valid -> next cycle grant_id=0. No write occurs in the cycle valid dropped.
- Overflow flag: inject a 1-cycle fifo_overflow pulse -> err_overflow=1 on the next edge and it stays 1 until rst_n is asserted.
